// File: rtl/term_op_sequencer_if.sv
// Command bus between the two requesters and the op sequencer, plus the
// datapath-facing op select / operand / status outputs.
interface term_op_sequencer_if #(
   parameter int NUM_OPS = 11
);
   logic               req0;
   logic [3:0]         op0;
   logic [7:0]         arg0;
   logic               ack0;
   logic               req1;
   logic [3:0]         op1;
   logic [7:0]         arg1;
   logic               ack1;
   logic [NUM_OPS-1:0] op_code;
   logic [7:0]         a;
   logic               busy;
   logic               err;

   // Requester / datapath side
   modport master (
      output req0, op0, arg0, req1, op1, arg1,
      input  ack0, ack1, op_code, a, busy, err
   );

   // Sequencer side
   modport slave (
      input  req0, op0, arg0, req1, op1, arg1,
      output ack0, ack1, op_code, a, busy, err
   );
endinterface

// File: rtl/term_op_sequencer.sv
// Two-requester round-robin command scheduler for the pseudo-terminal
// datapath. A granted op index is turned into a one-hot op_code that is held
// with its operand for HOLD_CYCLES cycles, followed by a one-cycle idle gap.
module term_op_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int NUM_OPS     = 11
) (
   input logic                clk,
   input logic                rst_n,
   term_op_sequencer_if.slave bus
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_OPS-1:0] op_code_q, op_code_d;
   logic [7:0]         a_q, a_d;
   logic               busy_q, busy_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               err_q, err_d;
   logic               last_q, last_d;   // 1: requester 1 was granted last

   logic               eff0, eff1;
   logic               gnt0, gnt1;
   logic [3:0]         sel_op;
   logic [7:0]         sel_arg;

   // Round-robin arbitration; a request seen in its own ack cycle belongs to
   // the command just captured and is not granted again.
   always_comb begin
      eff0    = bus.req0 & ~ack0_q;
      eff1    = bus.req1 & ~ack1_q;
      gnt0    = eff0 & (~eff1 | last_q);
      gnt1    = eff1 & ~gnt0;
      sel_op  = gnt1 ? bus.op1  : bus.op0;
      sel_arg = gnt1 ? bus.arg1 : bus.arg0;
   end

   // Next-state and registered-output logic for the IDLE/ISSUE/GAP sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_code_d = op_code_q;
      a_d       = a_q;
      busy_d    = busy_q;
      last_d    = last_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               ack0_d = gnt0;
               ack1_d = gnt1;
               last_d = gnt1;
               if (int'(sel_op) < NUM_OPS) begin
                  op_code_d = NUM_OPS'(1) << sel_op;
                  a_d       = sel_arg;
                  cnt_d     = CW'(HOLD_CYCLES - 1);
                  busy_d    = 1'b1;
                  state_d   = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (cnt_q == '0) begin
               op_code_d = '0;
               a_d       = '0;
               state_d   = S_GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_GAP: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_code_q <= '0;
         a_q       <= '0;
         busy_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         err_q     <= 1'b0;
         last_q    <= 1'b1;   // requester 0 wins the first tie
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_code_q <= op_code_d;
         a_q       <= a_d;
         busy_q    <= busy_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         err_q     <= err_d;
         last_q    <= last_d;
      end
   end

   assign bus.op_code = op_code_q;
   assign bus.a       = a_q;
   assign bus.busy    = busy_q;
   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.err     = err_q;

endmodule
